// File: rtl/booth_r4_mult_param_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, digit-select codes,
// and the iteration / chunk-count helpers.
package booth_r4_mult_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CALC,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_0,
    SEL_P1,
    SEL_P2,
    SEL_M1,
    SEL_M2
  } sel_t;

  // Radix-4 recode of one overlapping triplet {b(2i+1), b(2i), b(2i-1)}
  function automatic sel_t booth_sel(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return SEL_P1;
      3'b011:         return SEL_P2;
      3'b100:         return SEL_M2;
      3'b101, 3'b110: return SEL_M1;
      default:        return SEL_0;
    endcase
  endfunction

  function automatic int nit_of(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int chunks_of(input int width, input int bus_w);
    return width / bus_w;
  endfunction

endpackage

// File: rtl/booth_r4_mult_param_digit.sv
// Combinational radix-4 Booth digit: maps a triplet and the extended
// multiplicand onto the signed addend {0, +A, +2A, -A, -2A}.
module booth_r4_digit
  import booth_r4_mult_param_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic        [2:0]       triplet,
  input  logic signed [WIDTH+1:0] a_ext,
  output logic signed [WIDTH+2:0] addend
);

  logic signed [WIDTH+2:0] a_w;

  assign a_w = {a_ext[WIDTH+1], a_ext};

  always_comb begin
    addend = '0;
    case (booth_sel(triplet))
      SEL_P1:  addend = a_w;
      SEL_P2:  addend = a_w <<< 1;
      SEL_M1:  addend = -a_w;
      SEL_M2:  addend = -(a_w <<< 1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_param.sv
// Iterative radix-4 Booth multiplier: operands loaded MS chunk first over a
// narrow bus, one digit retired per clock, product held under a ready/get handshake.
module booth_r4_mult_param
  import booth_r4_mult_param_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BUS_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_md,
  input  logic [BUS_W-1:0]     in,
  input  logic                 in_valid,
  input  logic                 get,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   out
);

  localparam int NCHUNK = chunks_of(WIDTH, BUS_W);
  localparam int NIT    = nit_of(WIDTH);
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam int IW     = $clog2(NIT + 1);
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);
  localparam logic [IW-1:0] LAST_IT    = IW'(NIT);

  function automatic logic signed [WIDTH+1:0] ext(input logic [WIDTH-1:0] x, input logic md);
    return md ? {{2{x[WIDTH-1]}}, x} : {2'b00, x};
  endfunction

  state_t                  state;
  logic                    mode_q;
  logic [CW-1:0]           chunk_cnt;
  logic [IW-1:0]           iter_cnt;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic signed [WIDTH+1:0] a_ext_q;
  logic signed [WIDTH+2:0] p_hi;
  logic [WIDTH+2:0]        p_lo;
  logic [2*WIDTH-1:0]      out_q;

  logic [WIDTH-1:0]          a_next;
  logic [WIDTH-1:0]          b_next;
  logic signed [WIDTH+2:0]   addend;
  logic signed [WIDTH+2:0]   sum;
  logic signed [2*WIDTH+5:0] cat;
  logic signed [2*WIDTH+5:0] shifted;
  logic [2*WIDTH-1:0]        product;

  assign a_next = (a_q << BUS_W) | WIDTH'(in);
  assign b_next = (b_q << BUS_W) | WIDTH'(in);

  booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
    .triplet (p_lo[2:0]),
    .a_ext   (a_ext_q),
    .addend  (addend)
  );

  // Accumulate into the high half, then arithmetic-shift the whole pair by one digit
  assign sum     = p_hi + addend;
  assign cat     = {sum, p_lo};
  assign shifted = cat >>> 2;
  assign product = {p_hi[WIDTH-3:0], p_lo[WIDTH+2:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_q    <= 1'b0;
      chunk_cnt <= '0;
      iter_cnt  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_ext_q   <= '0;
      p_hi      <= '0;
      p_lo      <= '0;
      out_q     <= '0;
      busy      <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_LOAD_A;
            mode_q    <= signed_md;
            chunk_cnt <= '0;
            busy      <= 1'b1;
          end
        end
        ST_LOAD_A: begin
          if (in_valid) begin
            a_q <= a_next;
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt <= '0;
              state     <= ST_LOAD_B;
            end else begin
              chunk_cnt <= chunk_cnt + CW'(1);
            end
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            b_q <= b_next;
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt <= '0;
              iter_cnt  <= '0;
              a_ext_q   <= ext(a_q, mode_q);
              p_hi      <= '0;
              p_lo      <= {ext(b_next, mode_q), 1'b0};
              state     <= ST_CALC;
            end else begin
              chunk_cnt <= chunk_cnt + CW'(1);
            end
          end
        end
        ST_CALC: begin
          if (iter_cnt == LAST_IT) begin
            out_q <= product;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= ST_DONE;
          end else begin
            p_hi     <= shifted[2*WIDTH+5:WIDTH+3];
            p_lo     <= shifted[WIDTH+2:0];
            iter_cnt <= iter_cnt + IW'(1);
          end
        end
        ST_DONE: begin
          if (get) begin
            ready <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_booth_r4_mult_param.sv
// Self-checking bench for booth_r4_mult_param: directed corners plus a random
// sweep against a plain-arithmetic product model.
module tb_booth_r4_mult_param;

  localparam int WIDTH  = 16;
  localparam int BUS_W  = 8;
  localparam int NCHUNK = WIDTH / BUS_W;
  localparam int LAT0   = 2 * NCHUNK + (WIDTH / 2 + 1) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                signed_md = 1'b0;
  logic [BUS_W-1:0]    din = '0;
  logic                in_valid = 1'b0;
  logic                get = 1'b0;
  logic                busy;
  logic                ready;
  logic [2*WIDTH-1:0]  dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  booth_r4_mult_param #(.WIDTH(WIDTH), .BUS_W(BUS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_md (signed_md),
    .in        (din),
    .in_valid  (in_valid),
    .get       (get),
    .busy      (busy),
    .ready     (ready),
    .out       (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic md);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (md && a[WIDTH-1]) sa = sa - (64'sd1 <<< WIDTH);
    if (md && b[WIDTH-1]) sb = sb - (64'sd1 <<< WIDTH);
    p = sa * sb;
    return p[2*WIDTH-1:0];
  endfunction

  task automatic send_operand(input logic [WIDTH-1:0] v, input int stalls);
    logic [WIDTH-1:0] sh;
    for (int i = 0; i < NCHUNK; i++) begin
      for (int s = 0; s < stalls; s++) begin
        in_valid = 1'b0;
        din      = BUS_W'($urandom);
        get      = 1'b1;
        @(posedge clk); #1;
      end
      get      = 1'b0;
      sh       = v >> ((NCHUNK - 1 - i) * BUS_W);
      din      = sh[BUS_W-1:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Runs one transaction up to ready; lat counts edges from the start edge to ready
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic md, input int stalls, input bit noisy,
                         output int lat);
    int t0;
    start     = 1'b1;
    signed_md = md;
    @(posedge clk); #1;
    t0        = cyc;
    start     = noisy;
    signed_md = noisy ? ~md : md;
    send_operand(a, stalls);
    send_operand(b, stalls);
    if (noisy) begin
      in_valid = 1'b1;
      din      = BUS_W'($urandom);
    end
    for (int n = 0; n < 300 && !ready; n++) begin
      @(posedge clk); #1;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    lat      = cyc - t0;
    if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
  endtask

  task automatic release_txn(input logic [2*WIDTH-1:0] exp);
    get = 1'b1;
    @(posedge clk); #1;
    get = 1'b0;
    chk("get_ready_low", 64'(ready), 64'd0);
    chk("get_out_kept", 64'(dout), 64'(exp));
  endtask

  initial begin
    int lat;
    logic [WIDTH-1:0] ra, rb;
    logic rm;
    int rs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_out", 64'(dout), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned max
    run_txn(16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0, lat);
    chk("umax_out", 64'(dout), 64'hFFFE0001);
    chk("umax_lat", 64'(lat), 64'(LAT0));
    chk("umax_busy", 64'(busy), 64'd0);
    release_txn(32'hFFFE0001);

    // Signed corners
    run_txn(16'h8000, 16'h8000, 1'b1, 0, 1'b0, lat);
    chk("s_min_min", 64'(dout), 64'h40000000);
    release_txn(32'h40000000);
    run_txn(16'hFFFD, 16'h0005, 1'b1, 0, 1'b0, lat);
    chk("s_m3_x5", 64'(dout), 64'hFFFFFFF1);
    release_txn(32'hFFFFFFF1);
    run_txn(16'h7FFF, 16'h8000, 1'b1, 0, 1'b0, lat);
    chk("s_max_min", 64'(dout), 64'hC0008000);
    release_txn(32'hC0008000);

    // Load stalls, with get strobing while loading
    run_txn(16'h1234, 16'h5678, 1'b0, 3, 1'b0, lat);
    chk("stall_out", 64'(dout), 64'h06260060);
    chk("stall_lat", 64'(lat), 64'(LAT0 + 12));
    release_txn(32'h06260060);

    // Reset in the fourth CALC cycle
    start = 1'b1; signed_md = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    send_operand(16'h00FF, 0);
    send_operand(16'h0101, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("calc_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(ready), 64'd0);
    chk("abort_out", 64'(dout), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(16'd2, 16'd3, 1'b1, 0, 1'b0, lat);
    chk("after_abort_out", 64'(dout), 64'd6);
    release_txn(32'd6);

    // Start/in_valid/mode noise during LOAD/CALC must be ignored
    run_txn(16'hFFFB, 16'h0007, 1'b1, 0, 1'b1, lat);
    chk("noisy_out", 64'(dout), 64'(ref_mul(16'hFFFB, 16'h0007, 1'b1)));
    chk("noisy_lat", 64'(lat), 64'(LAT0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("ready_hold", 64'(ready), 64'd1);
    end
    get = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    get = 1'b0; start = 1'b0;
    chk("getstart_ready", 64'(ready), 64'd0);
    chk("getstart_busy", 64'(busy), 64'd0);
    chk("getstart_out", 64'(dout), 64'(ref_mul(16'hFFFB, 16'h0007, 1'b1)));
    @(posedge clk); #1;
    chk("getstart_idle", 64'(busy), 64'd0);

    // Random sweep
    for (int k = 0; k < 300; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rm = 1'($urandom);
      rs = $urandom_range(0, 2);
      run_txn(ra, rb, rm, rs, 1'b0, lat);
      chk("rand_out", 64'(dout), 64'(ref_mul(ra, rb, rm)));
      chk("rand_lat", 64'(lat), 64'(LAT0 + 2 * NCHUNK * rs));
      release_txn(ref_mul(ra, rb, rm));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
